// File: rtl/seqsub_pkg.sv
// Shared types and default geometry for the sequential subtractor.
package seqsub_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seqsub_subslice.sv
// Combinational SLICE-bit ripple-borrow subtractor: {bout, diff} = a - b - bin.
module subslice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] diff,
  output logic             bout
);

  logic [SLICE:0] res;

  // The extra top bit goes high exactly when the slice has to borrow.
  assign res  = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
  assign diff = res[SLICE-1:0];
  assign bout = res[SLICE];

endmodule

// File: rtl/seqsub.sv
// Multi-cycle subtractor DIFF = A - B, one SLICE-bit chunk per clock with a registered borrow.
// Optional signed-overflow output OVF is built only when SEQSUB_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice per cycle, indexed by idx
// DONE  | result held, out_valid high until out_ready
module seqsub
  import seqsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
`ifdef SEQSUB_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_geometry
    $error("seqsub: WIDTH must be a multiple of SLICE");
  end

  state_t                        state;
  logic [NSLICE-1:0][SLICE-1:0]  a_q;
  logic [NSLICE-1:0][SLICE-1:0]  b_q;
  logic [NSLICE-1:0][SLICE-1:0]  diff_q;
  logic [IDXW-1:0]               idx;
  logic                          borrow_q;
  logic [SLICE-1:0]              diff_s;
  logic                          bout_s;
  logic                          last_slice;

  assign last_slice = (state == RUN) && (idx == LAST);

  subslice #(.SLICE(SLICE)) u_slice (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .bin  (borrow_q),
    .diff (diff_s),
    .bout (bout_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      idx      <= '0;
      borrow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            idx      <= '0;
            borrow_q <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff_q[idx] <= diff_s;
          borrow_q    <= bout_s;
          if (idx == LAST) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign DIFF      = diff_q;
  assign BORROW    = borrow_q;

`ifdef SEQSUB_OVF_EN
  logic ovf_q;
  logic a_msb;
  logic b_msb;

  assign a_msb = a_q[NSLICE-1][SLICE-1];
  assign b_msb = b_q[NSLICE-1][SLICE-1];

  // Captured alongside the top slice so it is stable for all of DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_slice) begin
      ovf_q <= (a_msb ^ b_msb) & (diff_s[SLICE-1] ^ a_msb);
    end
  end

  assign OVF = ovf_q;
`endif

endmodule

// File: doc/seqsub.md
# seqsub

Multi-cycle unsigned/two's-complement subtractor computing DIFF = A − B one SLICE-bit chunk per clock, with a registered borrow chained between chunks. It is the subtract-side companion to the datapath's single-cycle ripple adder, for paths where a full-width borrow chain cannot close timing. It accepts operands on a valid/ready input handshake and returns the difference and borrow on a valid/ready output handshake.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; NSLICE = WIDTH/SLICE.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands A, B presented.
- in_ready  out  1  block can accept operands; high only in IDLE.
- A  in  WIDTH  minuend.
- B  in  WIDTH  subtrahend.
- out_valid  out  1  DIFF/BORROW (and OVF) valid; high only in DONE.
- out_ready  in  1  consumer takes result.
- DIFF  out  WIDTH  A − B mod 2^WIDTH.
- BORROW  out  1  1 iff A < B unsigned (final borrow-out).
- OVF  out  1  signed overflow; present only with SEQSUB_OVF_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready at an edge: latch A, B; clear slice index and borrow register; go RUN.
- RUN: each cycle, slice k = index computes A[k] − B[k] − borrow; writes DIFF[k]; stores borrow-out; increments index. On the edge processing slice NSLICE−1, go DONE.
- DONE: out_valid=1; DIFF, BORROW, OVF stable. On out_valid && out_ready, go IDLE.
- One operation in flight; in_valid ignored outside IDLE; changes on A/B after acceptance have no effect.
- BORROW = final registered borrow-out of slice NSLICE−1.
- OVF = (A[MSB] ≠ B[MSB]) && (DIFF[MSB] ≠ A[MSB]), using the latched operands.
- DIFF contents during RUN are partial and not meaningful; consumers use them only under out_valid.
- Reset (rst_n low, any time, including mid-RUN or in DONE): state IDLE, index 0, borrow 0, DIFF 0, BORROW 0, OVF 0, out_valid 0, in_ready 1. The in-flight operation is discarded; no output is produced for it.

## Timing
- Accept at edge E0. Slices 0..NSLICE−1 are computed at edges E1..E_NSLICE. out_valid rises after edge E_NSLICE: 4 cycles for defaults.
- If out_ready=1 when out_valid rises, the result is taken at the next edge; in_ready is high the following cycle.
- With in_valid and out_ready tied high, acceptances are NSLICE+2 cycles apart: 6 for defaults.
- out_ready low holds DONE indefinitely; outputs do not change.
- Combinational critical path: one SLICE-bit borrow chain plus index mux.

## Configuration
- SEQSUB_OVF_EN defined: OVF port and its register exist and behave as in Operation.
- SEQSUB_OVF_EN undefined: no OVF port and no OVF logic; all other behaviour and timing are identical.

## Structure
- Package seqsub_pkg holds the state enum (IDLE, RUN, DONE) and the default WIDTH and SLICE constants.
- One sub-module, subslice: combinational SLICE-bit ripple-borrow subtractor with inputs a, b, bin and outputs diff, bout. It is instantiated once and muxed by the slice index.
- Elaboration-time check: WIDTH % SLICE == 0.

## Test plan
- A=0x0000_0010, B=0x0000_0001 -> DIFF=0x0000_000F, BORROW=0; out_valid exactly 4 cycles after accept.
- A=0x0000_0000, B=0x0000_0001 -> DIFF=0xFFFF_FFFF, BORROW=1; borrow propagates through all 4 slices.
- A=0x8000_0000, B=0x0000_0001 -> DIFF=0x7FFF_FFFF, BORROW=0, OVF=1 with SEQSUB_OVF_EN. Without the macro, the build has no OVF port.
- Backpressure: out_ready low for 10 cycles in DONE, in_valid high with new A/B -> outputs stable, in_ready=0, no new op accepted. out_ready high -> IDLE next cycle.
- Reset mid-RUN after slice 1 -> out_valid=0, DIFF=0, in_ready=1 immediately. A following op A=0x1234_5678, B=0x0234_5678 -> DIFF=0x1000_0000.
- Back-to-back: in_valid and out_ready tied high, 100 random pairs -> each DIFF/BORROW matches the A−B model; accepts are 6 cycles apart.
